// File: rtl/game_sequencer_if.sv
// Handshake bundle between game_sequencer and its neighbours: button/collision
// inputs toward the sequencer, registered command pulses back out.
interface game_sequencer_if;
  logic       frame_tick;
  logic       shoot;
  logic       left;
  logic       right;
  logic       player_collision;
  logic       invader_collision;
  logic       bullet_done;
  logic [1:0] lives;
  logic [5:0] invaders_left;
  logic [2:0] state;
  logic       move_left;
  logic       move_right;
  logic       fire;
  logic       bullet_active;
  logic       invader_step;
  logic       clear_field;

  modport master (
    output frame_tick, shoot, left, right, player_collision, invader_collision,
           bullet_done, lives, invaders_left,
    input  state, move_left, move_right, fire, bullet_active, invader_step, clear_field
  );

  modport slave (
    input  frame_tick, shoot, left, right, player_collision, invader_collision,
           bullet_done, lives, invaders_left,
    output state, move_left, move_right, fire, bullet_active, invader_step, clear_field
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow FSM: turns buttons and frame ticks into one-cycle move/fire/step
// commands, and owns the single player bullet and the invader step cadence.
module game_sequencer #(
  parameter int RESPAWN_FRAMES = 120,
  parameter int STEP_START     = 32,
  parameter int STEP_MIN       = 4
) (
  input logic              clk,
  input logic              arst,
  game_sequencer_if.slave  sq
);
  localparam int MAXC = (RESPAWN_FRAMES > STEP_START) ? RESPAWN_FRAMES : STEP_START;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RESP_LD   = CW'(RESPAWN_FRAMES);
  localparam logic [CW-1:0] STEP_LD   = CW'(STEP_START);
  localparam logic [CW-1:0] STEP_FLR  = CW'(STEP_MIN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    RESPAWN    = 3'd2,
    WAVE_CLEAR = 3'd3,
    OVER       = 3'd4
  } st_t;

  st_t           st;
  logic          shoot_q;
  logic [CW-1:0] step_cnt, period, resp_cnt;
  logic          move_left_q, move_right_q, fire_q, bullet_q, step_q, clear_q;
  logic          rise;

  assign rise = sq.shoot & ~shoot_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      st           <= IDLE;
      shoot_q      <= 1'b0;
      step_cnt     <= '0;
      resp_cnt     <= '0;
      period       <= STEP_LD;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      bullet_q     <= 1'b0;
      step_q       <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      shoot_q      <= sq.shoot;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      step_q       <= 1'b0;
      clear_q      <= 1'b0;
      case (st)
        IDLE: if (rise) begin
          clear_q  <= 1'b1;
          period   <= STEP_LD;
          step_cnt <= STEP_LD;
          st       <= PLAY;
        end
        PLAY: begin
          if (sq.player_collision) begin
            bullet_q <= 1'b0;
            if (sq.lives <= 2'd1) st <= OVER;
            else begin
              resp_cnt <= RESP_LD;
              st       <= RESPAWN;
            end
          end else if (sq.invaders_left == '0) begin
            bullet_q <= 1'b0;
            resp_cnt <= RESP_LD;
            st       <= WAVE_CLEAR;
          end else begin
            if (sq.frame_tick) begin
              move_left_q  <= sq.left & ~sq.right;
              move_right_q <= sq.right & ~sq.left;
              if (step_cnt <= 1) begin
                step_q   <= 1'b1;
                step_cnt <= period;
              end else step_cnt <= step_cnt - 1'b1;
            end
            // A rise while the bullet is still flying is dropped, not queued.
            if (sq.bullet_done || sq.invader_collision) bullet_q <= 1'b0;
            if (rise && !bullet_q) begin
              fire_q   <= 1'b1;
              bullet_q <= 1'b1;
            end
            // Only the period speeds up; the running count finishes as loaded.
            if (sq.invader_collision)
              period <= (period > STEP_FLR) ? period - 1'b1 : STEP_FLR;
          end
        end
        RESPAWN, WAVE_CLEAR: begin
          if (resp_cnt == '0) begin
            st <= PLAY;
            if (st == WAVE_CLEAR) begin
              clear_q  <= 1'b1;
              period   <= STEP_LD;
              step_cnt <= STEP_LD;
            end
          end else if (sq.frame_tick) resp_cnt <= resp_cnt - 1'b1;
        end
        OVER: if (rise) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign sq.state         = st;
  assign sq.move_left     = move_left_q;
  assign sq.move_right    = move_right_q;
  assign sq.fire          = fire_q;
  assign sq.bullet_active = bullet_q;
  assign sq.invader_step  = step_q;
  assign sq.clear_field   = clear_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: hand-computed expectations for start,
// movement, step cadence, bullet ownership, respawn/wave-clear and reset abort.
module tb_game_sequencer;
  logic clk, arst;
  int n_cmp = 0, n_bad = 0;
  int n_ml = 0, n_mr = 0, n_fire = 0, n_step = 0, n_clr = 0;

  game_sequencer_if gif();

  game_sequencer #(.RESPAWN_FRAMES(120), .STEP_START(32), .STEP_MIN(4)) dut (
    .clk (clk),
    .arst(arst),
    .sq  (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gif.move_left)    n_ml++;
    if (gif.move_right)   n_mr++;
    if (gif.fire)         n_fire++;
    if (gif.invader_step) n_step++;
    if (gif.clear_field)  n_clr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      gif.frame_tick = 1'b1; cyc(); gif.frame_tick = 1'b0;
    end
  endtask

  // Frames until the next invader_step; -1 if none within the bound.
  task automatic ticks_to_step(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      gif.frame_tick = 1'b1; cyc(); gif.frame_tick = 1'b0;
      if (gif.invader_step) begin n = i; break; end
    end
  endtask

  task automatic pulse_ic(input int n);
    for (int i = 0; i < n; i++) begin
      gif.invader_collision = 1'b1; cyc(); gif.invader_collision = 1'b0;
    end
  endtask

  task automatic shoot_rise();
    gif.shoot = 1'b1; cyc(); gif.shoot = 1'b0;
  endtask

  initial begin
    int k, s_ml, s_mr, s_f, s_st, s_c;
    arst = 1'b0;
    gif.frame_tick = 0; gif.shoot = 0; gif.left = 0; gif.right = 0;
    gif.player_collision = 0; gif.invader_collision = 0; gif.bullet_done = 0;
    gif.lives = 2'd3; gif.invaders_left = 6'd40;
    #12;
    chk("rst_state", gif.state, 0);
    chk("rst_bullet", gif.bullet_active, 0);
    chk("rst_clear", gif.clear_field, 0);
    arst = 1'b1;
    cyc(); cyc();

    // start
    gif.shoot = 1'b1; cyc();
    chk("start_state", gif.state, 1);
    chk("start_clear", gif.clear_field, 1);
    gif.shoot = 1'b0; cyc();
    chk("start_clear_1cyc", gif.clear_field, 0);

    // movement
    s_ml = n_ml; s_mr = n_mr;
    gif.right = 1'b1; tick(3); gif.right = 1'b0; cyc();
    chk("move_right_cnt", n_mr - s_mr, 3);
    chk("move_left_none", n_ml - s_ml, 0);
    s_ml = n_ml; s_mr = n_mr;
    gif.left = 1'b1; gif.right = 1'b1; tick(1); gif.left = 0; gif.right = 0; cyc();
    chk("move_both_none", (n_ml - s_ml) + (n_mr - s_mr), 0);

    // step cadence: 4 ticks already used of the first 32
    ticks_to_step(k); chk("step_first", k, 28);
    ticks_to_step(k); chk("step_period32", k, 32);
    pulse_ic(30);
    ticks_to_step(k); chk("step_running_kept", k, 32);
    ticks_to_step(k); chk("step_min_a", k, 4);
    pulse_ic(1);
    ticks_to_step(k); chk("step_min_b", k, 4);

    // bullet ownership
    s_f = n_fire;
    gif.shoot = 1'b1; cyc();
    chk("fire_pulse", gif.fire, 1);
    chk("fire_active", gif.bullet_active, 1);
    gif.shoot = 1'b0; cyc();
    chk("fire_1cyc", gif.fire, 0);
    shoot_rise(); cyc();
    chk("fire_dropped", n_fire - s_f, 1);
    chk("still_active", gif.bullet_active, 1);
    gif.bullet_done = 1'b1; cyc(); gif.bullet_done = 1'b0;
    chk("done_clears", gif.bullet_active, 0);
    shoot_rise(); cyc();
    chk("second_fire", n_fire - s_f, 2);
    chk("second_active", gif.bullet_active, 1);
    gif.bullet_done = 1'b1; gif.invader_collision = 1'b1; cyc();
    gif.bullet_done = 1'b0; gif.invader_collision = 1'b0;
    chk("both_clear", gif.bullet_active, 0);

    // non-fatal hit
    shoot_rise();
    gif.player_collision = 1'b1; cyc(); gif.player_collision = 1'b0;
    chk("hit_respawn", gif.state, 2);
    chk("hit_bullet_clr", gif.bullet_active, 0);
    s_ml = n_ml; s_f = n_fire; s_st = n_step;
    gif.left = 1'b1;
    tick(119);
    chk("respawn_hold", gif.state, 2);
    tick(1); cyc();
    chk("respawn_exit", gif.state, 1);
    gif.left = 1'b0; cyc();
    chk("respawn_quiet", (n_ml - s_ml) + (n_fire - s_f) + (n_step - s_st), 0);

    // fatal hit, then restart
    gif.lives = 2'd1; gif.player_collision = 1'b1; cyc();
    gif.player_collision = 1'b0; gif.lives = 2'd3;
    chk("over_state", gif.state, 4);
    gif.shoot = 1'b1; cyc();
    chk("over_to_idle", gif.state, 0);
    chk("over_no_clear", gif.clear_field, 0);
    gif.shoot = 1'b0; cyc();
    gif.shoot = 1'b1; cyc();
    chk("restart_state", gif.state, 1);
    chk("restart_clear", gif.clear_field, 1);
    gif.shoot = 1'b0; cyc();

    // hit outranks wave clear
    gif.invaders_left = 6'd0; gif.lives = 2'd2; gif.player_collision = 1'b1; cyc();
    gif.player_collision = 1'b0; gif.invaders_left = 6'd40; gif.lives = 2'd3;
    chk("hit_over_wave", gif.state, 2);
    tick(120); cyc();
    chk("hit_over_wave_back", gif.state, 1);

    // wave clear resets the period
    pulse_ic(10);
    s_c = n_clr;
    gif.invaders_left = 6'd0; cyc(); gif.invaders_left = 6'd40;
    chk("wave_state", gif.state, 3);
    tick(120); cyc();
    chk("wave_exit", gif.state, 1);
    cyc();
    chk("wave_clear_once", n_clr - s_c, 1);
    ticks_to_step(k); chk("wave_step_a", k, 32);
    ticks_to_step(k); chk("wave_step_b", k, 32);

    // reset mid-respawn
    gif.player_collision = 1'b1; cyc(); gif.player_collision = 1'b0;
    chk("abort_pre", gif.state, 2);
    tick(50);
    s_c = n_clr;
    #2 arst = 1'b0; #1;
    chk("abort_state", gif.state, 0);
    chk("abort_bullet", gif.bullet_active, 0);
    chk("abort_pulses", {gif.move_left, gif.move_right, gif.fire, gif.invader_step, gif.clear_field}, 0);
    cyc(); cyc();
    arst = 1'b1;
    tick(20); cyc();
    chk("abort_no_clear", n_clr - s_c, 0);
    chk("abort_idle", gif.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the space invaders design. Sits between the debouncer, score_logic and the VGA-side entity logic. Converts debounced buttons and per-frame ticks into single-cycle movement, fire and invader-step commands. Owns the game state machine (idle, play, respawn pause, wave clear, game over) and the single-player-bullet resource.

## Interface
- RESPAWN_FRAMES, 120: frames of pause after a non-fatal player hit, and after a wave is cleared.
- STEP_START, 32: frames between invader steps at the start of every wave.
- STEP_MIN, 4: floor for the invader step period.
- clk  in  1  system clock; all logic rises on clk.
- arst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- shoot, left, right  in  1  debounced button levels.
- player_collision  in  1  one-cycle pulse: player hit.
- invader_collision  in  1  one-cycle pulse: player bullet hit an invader.
- bullet_done  in  1  one-cycle pulse: player bullet left the screen.
- lives  in  2  current lives from score_logic; pre-decrement value in the player_collision cycle.
- invaders_left  in  6  invaders still alive, 0..40.
- state  out  3  0 IDLE, 1 PLAY, 2 RESPAWN, 3 WAVE_CLEAR, 4 OVER.
- move_left, move_right  out  1  one-cycle player move pulses.
- fire  out  1  one-cycle bullet launch pulse.
- bullet_active  out  1  level: player bullet in flight.
- invader_step  out  1  one-cycle invader formation step pulse.
- clear_field  out  1  one-cycle pulse: re-initialise invaders, player and bullets.

## Operation
- Internal shoot edge detect: shoot_q register; rise = shoot & ~shoot_q.
- IDLE:
  - On rise: clear_field, step period := STEP_START, step counter := STEP_START, go to PLAY.
- PLAY, on frame_tick:
  - move_left if left & ~right; move_right if right & ~left; both or neither gives no move.
  - Step counter decrements. When it is 1 on a tick: invader_step, reload counter with the current period.
- PLAY, fire:
  - On rise with bullet_active=0: fire and set bullet_active.
  - A rise while bullet_active=1 is dropped, not queued.
- PLAY, bullet_active cleared by bullet_done or invader_collision.
- PLAY, on invader_collision: period := max(STEP_MIN, period-1). The running counter is unaffected.
- PLAY, on player_collision:
  - Clear bullet_active.
  - If lives <= 1, go to OVER.
  - Otherwise load respawn counter with RESPAWN_FRAMES and go to RESPAWN.
- PLAY, invaders_left == 0 with no player_collision that cycle: clear bullet_active, load respawn counter, go to WAVE_CLEAR.
- Priority in the same cycle: player_collision > invaders_left==0 > normal play.
- RESPAWN:
  - Counter decrements on frame_tick; leave at 0 for PLAY.
  - No move, fire or step pulses are generated; all collision inputs are ignored.
  - The step counter holds its value.
- WAVE_CLEAR:
  - Same countdown as RESPAWN.
  - At exit: clear_field, period and step counter := STEP_START, go to PLAY.
- OVER: on rise go to IDLE (no clear_field). A second rise starts a new game.
- Counter widths: at least clog2(max(RESPAWN_FRAMES, STEP_START)+1) bits. No wrap; the step period never goes below STEP_MIN.

## Timing
- All outputs are registered. Each pulse is high exactly one cycle, in the cycle after the qualifying input is sampled.
- shoot rising at cycle N: fire at N+1, bullet_active high from N+1.
- frame_tick at N: move pulses and invader_step at N+1.
- State changes are visible on state the cycle after the triggering input.
- Reset values while arst=0, asynchronously:
  - state=IDLE and shoot_q=0.
  - All pulse outputs and bullet_active are 0.
  - Counters are 0, and period=STEP_START.
- Reset mid-game aborts immediately; no clear_field is issued until the next start from IDLE.
- frame_tick, shoot rise and collisions may coincide; each is handled independently, subject to the priorities above.

## Test plan
- Reset, then shoot rise: state 0→1 one cycle later, clear_field high one cycle. Hold right over 3 frame_ticks: exactly 3 move_right pulses, no move_left.
- PLAY with STEP_START=32: invader_step fires on the 32nd frame_tick after start, then every 32. After 30 invader_collisions the period is 4 (STEP_MIN) and stays 4.
- Fire, then press shoot again before bullet_done: only one fire pulse. bullet_done, then shoot: a second fire. bullet_done and invader_collision in the same cycle clear bullet_active once.
- player_collision with lives=3: state 2, no pulses for 120 frame_ticks, then state 1. Collision with lives=1: state 4. A shoot rise gives 0, a second rise gives 1 with clear_field.
- invaders_left=0 and player_collision in the same cycle with lives=2: state 2, not 3. invaders_left=0 alone: state 3, then after 120 ticks clear_field and the period reset to 32.
- Assert arst during RESPAWN with a counter mid-count: outputs zero immediately, state 0, and no clear_field after release.
